// File: rtl/task_map_pkg.sv
// Shared types and helpers for the task-graph sequencer: FSM state encoding,
// default sizing and the row-major matrix address function.
package task_map_pkg;

  localparam int DEF_NUM_V  = 3;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PRESENT,
    FINISH
  } seq_state_t;

  function automatic int unsigned addr_of(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned num_v = DEF_NUM_V);
    return row * num_v + col;
  endfunction

endpackage

// File: rtl/task_graph_sequencer_if.sv
// Bundles the adjacency-memory read port and the task_mapper entry stream.
// master = sequencer side, slave = memory/task_mapper side.
interface task_graph_sequencer_if
  import task_map_pkg::*;
#(
  parameter int NUM_V  = DEF_NUM_V,
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = $clog2(NUM_V * NUM_V)
);

  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rd_data;

  logic [DATA_W-1:0] task_array;
  logic              task_valid;
  logic              task_ready;
  logic              root_task;
  logic [AW-1:0]     cur_row;
  logic [AW-1:0]     cur_col;

  modport master (
    output mem_rd_en, mem_addr, task_array, task_valid, root_task, cur_row, cur_col,
    input  mem_rd_data, task_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, task_array, task_valid, root_task, cur_row, cur_col,
    output mem_rd_data, task_ready
  );

endinterface

// File: rtl/tg_scan_counter.sv
// Row-major row/col walker over an NUM_V x NUM_V matrix; last flags the
// bottom-right entry so the controller can finish instead of advancing.
module tg_scan_counter #(
  parameter int NUM_V = 3,
  parameter int AW    = $clog2(NUM_V * NUM_V)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last
);

  localparam logic [AW-1:0] MAX_IDX = AW'(NUM_V - 1);

  logic [AW-1:0] row_reg;
  logic [AW-1:0] col_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (advance) begin
      if (col_reg == MAX_IDX) begin
        col_reg <= '0;
        row_reg <= row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  assign row  = row_reg;
  assign col  = col_reg;
  assign last = (row_reg == MAX_IDX) && (col_reg == MAX_IDX);

endmodule

// File: rtl/task_graph_sequencer.sv
// Streams an adjacency matrix from a registered-read memory to task_mapper,
// one entry per handshake, flagging the first non-zero edge and counting edges.
module task_graph_sequencer
  import task_map_pkg::*;
#(
  parameter int NUM_V  = DEF_NUM_V,
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = $clog2(NUM_V * NUM_V),
  parameter int CW     = $clog2(NUM_V * NUM_V + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  task_graph_sequencer_if.master bus,
  output logic [CW-1:0]          edge_count,
  output logic                   busy,
  output logic                   done
);

  localparam logic [CW-1:0] EDGE_MAX = CW'(NUM_V * NUM_V);

  seq_state_t state_reg;
  seq_state_t state_next;

  logic [DATA_W-1:0] task_array_reg;
  logic              root_reg;
  logic              root_seen_reg;
  logic [AW-1:0]     cur_row_reg;
  logic [AW-1:0]     cur_col_reg;
  logic [CW-1:0]     edge_count_reg;

  logic          scan_clear;
  logic          scan_advance;
  logic          accept;
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic          last;

  tg_scan_counter #(
    .NUM_V (NUM_V),
    .AW    (AW)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .clear   (scan_clear),
    .advance (scan_advance),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // abort outranks both start (in IDLE) and the PRESENT handshake.
  always_comb begin
    state_next   = state_reg;
    scan_clear   = 1'b0;
    scan_advance = 1'b0;
    accept       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = READ;
          scan_clear = 1'b1;
        end
      end
      READ:    state_next = abort ? IDLE : WAIT;
      WAIT:    state_next = abort ? IDLE : PRESENT;
      PRESENT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (bus.task_ready) begin
          accept = 1'b1;
          if (last) begin
            state_next = FINISH;
          end else begin
            state_next   = READ;
            scan_advance = 1'b1;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      task_array_reg <= '0;
      root_reg       <= 1'b0;
      root_seen_reg  <= 1'b0;
      cur_row_reg    <= '0;
      cur_col_reg    <= '0;
      edge_count_reg <= '0;
    end else begin
      if (scan_clear) begin
        edge_count_reg <= '0;
        root_seen_reg  <= 1'b0;
      end
      // Root is decided at capture time so it stays aligned with task_array.
      if (state_reg == WAIT && !abort) begin
        task_array_reg <= bus.mem_rd_data;
        root_reg       <= (bus.mem_rd_data != '0) && !root_seen_reg;
        cur_row_reg    <= row;
        cur_col_reg    <= col;
      end
      if (accept && task_array_reg != '0) begin
        root_seen_reg <= 1'b1;
        if (edge_count_reg != EDGE_MAX) begin
          edge_count_reg <= edge_count_reg + CW'(1);
        end
      end
    end
  end

  assign bus.mem_rd_en  = (state_reg == READ);
  assign bus.mem_addr   = AW'(addr_of(32'(row), 32'(col), NUM_V));
  assign bus.task_array = task_array_reg;
  assign bus.task_valid = (state_reg == PRESENT);
  assign bus.root_task  = (state_reg == PRESENT) && root_reg;
  assign bus.cur_row    = cur_row_reg;
  assign bus.cur_col    = cur_col_reg;

  assign edge_count = edge_count_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == FINISH);

endmodule

// File: tb/tb_task_graph_sequencer.sv
// Directed bench for task_graph_sequencer: a registered-read matrix memory model
// plus per-scenario tasks comparing captured handshakes against hand-worked values.
module tb_task_graph_sequencer;

  localparam int NUM_V  = 3;
  localparam int DATA_W = 32;
  localparam int AW     = $clog2(NUM_V * NUM_V);
  localparam int CW     = $clog2(NUM_V * NUM_V + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] edge_count;
  logic          busy;
  logic          done;

  task_graph_sequencer_if #(.NUM_V(NUM_V), .DATA_W(DATA_W)) bus ();

  task_graph_sequencer #(
    .NUM_V  (NUM_V),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .bus        (bus),
    .edge_count (edge_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [NUM_V*NUM_V];

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  int exp_a [9] = '{0, 5, 0, 5, 0, 6, 0, 6, 0};

  int n_cmp = 0;
  int n_err = 0;

  int hs_val  [16];
  int hs_root [16];
  int hs_row  [16];
  int hs_col  [16];
  int n_hs, n_done, done_cyc, n_root, stall_changes;
  int st_val, st_row, st_col;
  bit busy_after_done, post_abort_busy, post_abort_valid;

  task automatic load_mem(input bit zero);
    for (int i = 0; i < NUM_V*NUM_V; i++) mem[i] = zero ? '0 : DATA_W'(exp_a[i]);
  endtask

  // Runs one scan from a start pulse for a fixed 45-cycle window, recording every
  // handshake; optional stall, abort and mid-scan start are injected by index/cycle.
  task automatic capture(input int stall_idx, input int stall_len,
                         input int abort_idx, input int busy_start);
    int  stall_cnt;
    bit  after_abort;
    n_hs = 0; n_done = 0; done_cyc = -1; n_root = 0; stall_changes = 0;
    busy_after_done = 0; post_abort_busy = 0; post_abort_valid = 0;
    st_val = -1; st_row = -1; st_col = -1;
    stall_cnt = 0; after_abort = 0;
    @(negedge clk);
    start = 1'b1;
    bus.task_ready = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      start = (cyc == busy_start);
      abort = 1'b0;
      bus.task_ready = 1'b1;
      if (after_abort) begin
        post_abort_busy  = busy;
        post_abort_valid = bus.task_valid | bus.root_task;
        after_abort = 0;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end else if (done_cyc >= 0 && busy) begin
        busy_after_done = 1;
      end
      if (bus.root_task) n_root++;
      if (bus.task_valid) begin
        if (n_hs == abort_idx) begin
          abort = 1'b1;
          after_abort = 1;
        end else if (n_hs == stall_idx && stall_cnt < stall_len) begin
          if (stall_cnt == 0) begin
            st_val = int'(bus.task_array);
            st_row = int'(bus.cur_row);
            st_col = int'(bus.cur_col);
          end else if (int'(bus.task_array) != st_val || int'(bus.cur_row) != st_row ||
                       int'(bus.cur_col) != st_col || bus.root_task) begin
            stall_changes++;
          end
          bus.task_ready = 1'b0;
          stall_cnt++;
        end else if (n_hs < 16) begin
          hs_val[n_hs]  = int'(bus.task_array);
          hs_root[n_hs] = int'(bus.root_task);
          hs_row[n_hs]  = int'(bus.cur_row);
          hs_col[n_hs]  = int'(bus.cur_col);
          n_hs++;
        end
      end else if (stall_cnt > 0 && stall_cnt < stall_len) begin
        stall_changes++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    bus.task_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (bus.task_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.task_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (edge_count !== '0) begin n_err++; $display("FAIL reset_edge_count: got %0d want 0", edge_count); end
    n_cmp++; if (bus.mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", bus.mem_rd_en); end
    n_cmp++; if (bus.task_array !== '0) begin n_err++; $display("FAIL reset_task_array: got %0d want 0", bus.task_array); end
    rst = 1'b0;
    $display("test_reset: outputs checked during reset");
  endtask

  task automatic test_basic_scan;
    load_mem(1'b0);
    capture(-1, 0, -1, -1);
    n_cmp++; if (n_hs !== 9) begin n_err++; $display("FAIL basic_handshakes: got %0d want 9", n_hs); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (hs_val[i] !== exp_a[i]) begin n_err++; $display("FAIL basic_value[%0d]: got %0d want %0d", i, hs_val[i], exp_a[i]); end
      n_cmp++; if (hs_root[i] !== int'(i == 1)) begin n_err++; $display("FAIL basic_root[%0d]: got %0d want %0d", i, hs_root[i], int'(i == 1)); end
      n_cmp++; if (hs_row[i] !== i / 3 || hs_col[i] !== i % 3) begin
        n_err++; $display("FAIL basic_rowcol[%0d]: got (%0d,%0d) want (%0d,%0d)", i, hs_row[i], hs_col[i], i / 3, i % 3);
      end
    end
    n_cmp++; if (n_root !== 1) begin n_err++; $display("FAIL basic_root_cycles: got %0d want 1", n_root); end
    n_cmp++; if (done_cyc !== 28) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 28", done_cyc); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
    n_cmp++; if (edge_count !== CW'(4)) begin n_err++; $display("FAIL basic_edge_count: got %0d want 4", edge_count); end
    $display("test_basic_scan: %0d handshakes, done at cycle %0d, edge_count %0d", n_hs, done_cyc, edge_count);
  endtask

  task automatic test_backpressure;
    load_mem(1'b0);
    capture(5, 5, -1, -1);
    n_cmp++; if (stall_changes !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", stall_changes); end
    n_cmp++; if (st_val !== 6) begin n_err++; $display("FAIL bp_task_array: got %0d want 6", st_val); end
    n_cmp++; if (st_row !== 1 || st_col !== 2) begin n_err++; $display("FAIL bp_rowcol: got (%0d,%0d) want (1,2)", st_row, st_col); end
    n_cmp++; if (n_hs !== 9) begin n_err++; $display("FAIL bp_handshakes: got %0d want 9", n_hs); end
    n_cmp++; if (done_cyc !== 33) begin n_err++; $display("FAIL bp_done_cycle: got %0d want 33", done_cyc); end
    n_cmp++; if (edge_count !== CW'(4)) begin n_err++; $display("FAIL bp_edge_count: got %0d want 4", edge_count); end
    $display("test_backpressure: stalled entry (%0d,%0d)=%0d, done at cycle %0d", st_row, st_col, st_val, done_cyc);
  endtask

  task automatic test_all_zero;
    load_mem(1'b1);
    capture(-1, 0, -1, -1);
    n_cmp++; if (n_hs !== 9) begin n_err++; $display("FAIL zero_handshakes: got %0d want 9", n_hs); end
    n_cmp++; if (n_root !== 0) begin n_err++; $display("FAIL zero_root: got %0d want 0", n_root); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL zero_done: got %0d want 1", n_done); end
    n_cmp++; if (edge_count !== '0) begin n_err++; $display("FAIL zero_edge_count: got %0d want 0", edge_count); end
    $display("test_all_zero: %0d handshakes, edge_count %0d", n_hs, edge_count);
  endtask

  task automatic test_abort;
    load_mem(1'b0);
    capture(-1, 0, 3, -1);
    n_cmp++; if (n_hs !== 3) begin n_err++; $display("FAIL abort_handshakes: got %0d want 3", n_hs); end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL abort_done: got %0d want 0", n_done); end
    n_cmp++; if (post_abort_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", post_abort_busy); end
    n_cmp++; if (post_abort_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", post_abort_valid); end
    n_cmp++; if (edge_count !== CW'(1)) begin n_err++; $display("FAIL abort_edge_count: got %0d want 1", edge_count); end
    capture(-1, 0, -1, -1);
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (hs_root[i] !== int'(i == 1)) begin n_err++; $display("FAIL rescan_root[%0d]: got %0d want %0d", i, hs_root[i], int'(i == 1)); end
    end
    n_cmp++; if (edge_count !== CW'(4)) begin n_err++; $display("FAIL rescan_edge_count: got %0d want 4", edge_count); end
    $display("test_abort: aborted after 3 handshakes, rescan edge_count %0d", edge_count);
  endtask

  task automatic test_reset_mid_scan;
    load_mem(1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    bus.task_ready = 1'b1;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || bus.task_valid !== 1'b0 || bus.root_task !== 1'b0 || done !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      n_err++; $display("FAIL midrst_ctrl: got busy=%b valid=%b root=%b done=%b rd=%b want all 0",
                        busy, bus.task_valid, bus.root_task, done, bus.mem_rd_en);
    end
    n_cmp++; if (edge_count !== '0) begin n_err++; $display("FAIL midrst_edge_count: got %0d want 0", edge_count); end
    n_cmp++; if (bus.task_array !== '0) begin n_err++; $display("FAIL midrst_task_array: got %0d want 0", bus.task_array); end
    n_cmp++; if (bus.cur_row !== '0 || bus.cur_col !== '0) begin
      n_err++; $display("FAIL midrst_rowcol: got (%0d,%0d) want (0,0)", bus.cur_row, bus.cur_col);
    end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle_after: got busy=%b want 0", busy); end
    capture(-1, 0, -1, -1);
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (hs_val[i] !== exp_a[i] || hs_root[i] !== int'(i == 1)) begin
        n_err++; $display("FAIL midrst_entry[%0d]: got val=%0d root=%0d want val=%0d root=%0d",
                          i, hs_val[i], hs_root[i], exp_a[i], int'(i == 1));
      end
    end
    n_cmp++; if (done_cyc !== 28) begin n_err++; $display("FAIL midrst_done_cycle: got %0d want 28", done_cyc); end
    n_cmp++; if (edge_count !== CW'(4)) begin n_err++; $display("FAIL midrst_edge_count: got %0d want 4", edge_count); end
    $display("test_reset_mid_scan: rescan done at cycle %0d, edge_count %0d", done_cyc, edge_count);
  endtask

  task automatic test_start_while_busy;
    load_mem(1'b0);
    capture(-1, 0, -1, 8);
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL busy_start_done_count: got %0d want 1", n_done); end
    n_cmp++; if (done_cyc !== 28) begin n_err++; $display("FAIL busy_start_done_cycle: got %0d want 28", done_cyc); end
    n_cmp++; if (n_hs !== 9) begin n_err++; $display("FAIL busy_start_handshakes: got %0d want 9", n_hs); end
    n_cmp++; if (busy_after_done !== 1'b0) begin n_err++; $display("FAIL busy_start_restart: got %b want 0", busy_after_done); end
    n_cmp++; if (edge_count !== CW'(4)) begin n_err++; $display("FAIL busy_start_edge_count: got %0d want 4", edge_count); end
    $display("test_start_while_busy: single done at cycle %0d", done_cyc);
  endtask

  initial begin
    bus.task_ready = 1'b1;
    load_mem(1'b0);
    test_reset();
    test_basic_scan();
    test_backpressure();
    test_all_zero();
    test_abort();
    test_reset_mid_scan();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/task_graph_sequencer.md
Name: task_graph_sequencer

Overview:
- Controller that streams a task-graph adjacency matrix from a single-port read memory into task_mapper, one entry per handshake, in row-major order.
- Flags the root task (first non-zero edge of the scan) and counts non-zero edges.
- Sits between the application-graph storage and task_mapper, replacing bench-driven task_array/root_task stimulus.

Parameters:
- NUM_V, 3, number of vertices; matrix is NUM_V x NUM_V.
- DATA_W, 32, edge-weight width (task_array width).
- AW, $clog2(NUM_V*NUM_V), memory address width.
- CW, $clog2(NUM_V*NUM_V+1), edge_count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin scan; ignored unless IDLE.
- abort  in  1  pulse: terminate scan, return to IDLE, no done.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  AW  read address = row*NUM_V+col.
- mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en.
- task_array  out  DATA_W  current matrix entry to task_mapper.
- task_valid  out  1  task_array/root_task valid.
- task_ready  in  1  task_mapper accepts the entry when task_valid && task_ready.
- root_task  out  1  high with task_valid for the first non-zero entry only.
- cur_row  out  AW  row index of the presented entry.
- cur_col  out  AW  column index of the presented entry.
- edge_count  out  CW  non-zero entries accepted this scan.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE; all outputs 0, including task_array, edge_count, cur_row/col and the internal root_seen flag. A reset mid-scan discards the scan; the first READ follows only a new start.
- FSM states: IDLE, READ, WAIT, PRESENT, FINISH.
  - IDLE: on start, clear edge_count, root_seen, row and col, then go to READ.
  - READ: drive mem_rd_en=1 and mem_addr for one cycle, then go to WAIT.
  - WAIT: register mem_rd_data into task_array, set cur_row/cur_col, then go to PRESENT.
  - PRESENT: task_valid=1. task_array, root_task, cur_row and cur_col stay stable until handshake.
  - On handshake in PRESENT: if entry!=0, increment edge_count and set root_seen. If this is the last entry (row=col=NUM_V-1), go to FINISH; otherwise advance col (wrap to 0 and increment row at NUM_V-1) and go to READ.
  - FINISH: done=1 for one cycle, then IDLE.
- root_task = task_valid && entry!=0 && !root_seen (registered with task_array).
- Zero entries are presented and handshaken like any other entry; they never assert root_task.
- Minimum cadence is 3 cycles per entry with task_ready held high. A full 3x3 scan takes 27 cycles, plus 1 cycle for FINISH.
- Backpressure: task_ready low holds PRESENT indefinitely with outputs unchanged.
- edge_count keeps its final value after done until the next start. It saturates at NUM_V*NUM_V; it cannot exceed this by construction.
- abort has priority over handshake and start in any non-IDLE state. Next cycle: IDLE, task_valid=0, root_task=0, no done, edge_count frozen.
- start while busy is ignored. start and abort in the same cycle while IDLE: abort wins and the block stays IDLE.
- All-zero matrix: all NUM_V*NUM_V entries are presented, root_task is never asserted, and done fires with edge_count=0.

Decomposition:
- Package task_map_pkg holds:
  - the state enum (seq_state_t: IDLE, READ, WAIT, PRESENT, FINISH);
  - the DATA_W default;
  - a function addr_of(row,col) returning row*NUM_V+col.
- Sub-module tg_scan_counter holds the row/col counter.
  - Inputs: clear, advance.
  - Outputs: row, col, last.
- FSM, data register and root/edge logic stay in task_graph_sequencer.

Test Plan:
- Matrix {0,5,0; 5,0,6; 0,6,0}, task_ready=1, start pulse -> 9 handshakes in order 0,5,0,5,0,6,0,6,0. root_task only on (row0,col1,5). done 28 cycles after start. edge_count=4.
- Same matrix, task_ready low for 5 cycles on entry (1,2) -> task_valid held, task_array=6, cur_row=1, cur_col=2 stable. Completion 5 cycles later; edge_count=4.
- All-zero matrix -> 9 handshakes, root_task never high, done with edge_count=0.
- abort during PRESENT of entry 4 -> IDLE next cycle, no done, edge_count=1. A subsequent start rescans from (0,0) and root_task fires on (0,1) again.
- rst asserted mid-scan, then start -> all outputs 0 during reset. The new scan repeats scenario 1 results exactly.
- start pulsed while busy -> ignored; the current scan completes normally with a single done.
